// File: rtl/ann_window_sequencer.sv
// ann_window_sequencer
//
// Sequences the per-window neuron evaluation that feeds the face classifier.
// One start runs N_WINDOWS windows back to back, which is one classifier
// decision frame. Each window walks N_INPUTS pixel/weight pairs, accumulates
// their signed products, adds the bias, and presents the result on Z with a
// one-cycle classify strobe.
//
// Optional feature macro: ANN_SEQ_ABORT_EN
//   defined     -> adds input 'abort'. It returns any running frame to IDLE
//                  without classify or done, and Z keeps its last value.
//   not defined -> no abort port; only RST interrupts a frame.
//
// Ports
//   Clk       in   1        system clock, all state on rising edge
//   RST       in   1        synchronous active-high reset
//   start     in   1        begin a frame (sampled only in IDLE)
//   pix_addr  out  PIX_AW   pixel RAM read address
//   pix_data  in   8        signed pixel, valid one cycle after address
//   wt_addr   out  WT_AW    weight RAM read address
//   wt_data   in   8        signed weight, valid one cycle after address
//   bias      in   16       signed bias, static during a frame
//   Z         out  32       signed neuron sum, registered
//   classify  out  1        one-cycle strobe, Z valid while high
//   win_idx   out  8        current window 0..N_WINDOWS-1
//   busy      out  1        high in every state except IDLE
//   done      out  1        one-cycle pulse after the final window's strobe
//   abort     in   1        (ANN_SEQ_ABORT_EN only) cancel the running frame
//
// Parameters
//   N_INPUTS  products per window
//   N_WINDOWS windows per frame
//   PIX_AW    pixel address width, 2**PIX_AW >= N_INPUTS*N_WINDOWS
//   WT_AW     weight address width, 2**WT_AW >= N_INPUTS

module ann_window_sequencer #(
    parameter int N_INPUTS  = 64,
    parameter int N_WINDOWS = 42,
    parameter int PIX_AW    = 12,
    parameter int WT_AW     = 6
) (
    input  logic              Clk,
    input  logic              RST,
    input  logic              start,
    output logic [PIX_AW-1:0] pix_addr,
    input  logic [7:0]        pix_data,
    output logic [WT_AW-1:0]  wt_addr,
    input  logic [7:0]        wt_data,
    input  logic [15:0]       bias,
    output logic [31:0]       Z,
    output logic              classify,
    output logic [7:0]        win_idx,
    output logic              busy,
`ifdef ANN_SEQ_ABORT_EN
    input  logic              abort,
`endif
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [WT_AW-1:0] K_LAST = WT_AW'(N_INPUTS - 1);
    localparam logic [7:0]       W_LAST = 8'(N_WINDOWS - 1);

    state_t            r_state;
    logic [WT_AW-1:0]  r_k;          // element index inside the window; doubles as wt_addr
    logic [PIX_AW-1:0] r_pix_addr;
    logic [23:0]       r_acc;
    logic [31:0]       r_z;
    logic              r_classify;
    logic [7:0]        r_win_idx;
    logic              r_busy;
    logic              r_done;

    logic              w_abort;
    logic [15:0]       w_pix_ext;
    logic [15:0]       w_wt_ext;
    logic [15:0]       w_prod;
    logic [23:0]       w_acc_plus;
    logic [23:0]       w_sum;

`ifdef ANN_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Sign-extend both operands to 16 bits; the low 16 bits of the unsigned
    // product then equal the signed 8x8 product, which always fits in 16 bits.
    assign w_pix_ext  = {{8{pix_data[7]}}, pix_data};
    assign w_wt_ext   = {{8{wt_data[7]}}, wt_data};
    assign w_prod     = w_pix_ext * w_wt_ext;
    assign w_acc_plus = r_acc + {{8{w_prod[15]}}, w_prod};
    assign w_sum      = w_acc_plus + {{8{bias[15]}}, bias};

    always_ff @(posedge Clk) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_pix_addr <= '0;
            r_acc      <= '0;
            r_z        <= '0;
            r_classify <= 1'b0;
            r_win_idx  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_abort && (r_state != S_IDLE)) begin
            // Cancel the frame: no strobe, no done, Z untouched.
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_acc      <= '0;
            r_classify <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_k        <= '0;
                    r_win_idx  <= '0;
                    r_acc      <= '0;
                    r_classify <= 1'b0;
                    r_done     <= 1'b0;
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_busy     <= 1'b1;
                        r_pix_addr <= '0;
                    end
                end

                S_LOAD: begin
                    // RAM data lags the address by one cycle, so the first
                    // LOAD cycle has no product to accumulate yet.
                    if (r_k != '0) begin
                        r_acc <= w_acc_plus;
                    end
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k        <= r_k + WT_AW'(1);
                        r_pix_addr <= r_pix_addr + PIX_AW'(1);
                    end
                end

                S_DRAIN: begin
                    r_z        <= {{8{w_sum[23]}}, w_sum};
                    r_classify <= 1'b1;
                    r_state    <= S_EMIT;
                end

                S_EMIT: begin
                    r_classify <= 1'b0;
                    r_acc      <= '0;
                    r_k        <= '0;
                    if (r_win_idx == W_LAST) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        // Windows are contiguous in pixel memory, so the next
                        // base is simply one past the last address used.
                        r_win_idx  <= r_win_idx + 8'd1;
                        r_pix_addr <= r_pix_addr + PIX_AW'(1);
                        r_state    <= S_LOAD;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pix_addr = r_pix_addr;
    assign wt_addr  = r_k;
    assign Z        = r_z;
    assign classify = r_classify;
    assign win_idx  = r_win_idx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_ann_window_sequencer.sv
module tb_ann_window_sequencer;

    localparam int NI    = 64;
    localparam int NW    = 42;
    localparam int WP    = NI + 2;
    localparam int FRAME = NW * WP + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default-parameter DUT ----------------
    logic        rst, start;
    logic [11:0] pix_addr;
    logic [5:0]  wt_addr;
    logic [7:0]  pix_data, wt_data;
    logic [15:0] bias;
    logic [31:0] Z;
    logic        classify, busy, done;
    logic [7:0]  win_idx;
`ifdef ANN_SEQ_ABORT_EN
    logic        abort;
`endif

    logic [7:0] pix_mem [4096];
    logic [7:0] wt_mem  [64];

    always @(posedge clk) begin
        pix_data <= pix_mem[pix_addr];
        wt_data  <= wt_mem[wt_addr];
    end

    ann_window_sequencer dut (
        .Clk      (clk),
        .RST      (rst),
        .start    (start),
        .pix_addr (pix_addr),
        .pix_data (pix_data),
        .wt_addr  (wt_addr),
        .wt_data  (wt_data),
        .bias     (bias),
        .Z        (Z),
        .classify (classify),
        .win_idx  (win_idx),
        .busy     (busy),
`ifdef ANN_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .done     (done)
    );

    // ---------------- single-window DUT ----------------
    logic        start_s;
    logic [3:0]  pix_addr_s;
    logic [1:0]  wt_addr_s;
    logic [7:0]  pix_data_s, wt_data_s;
    logic [15:0] bias_s;
    logic [31:0] Z_s;
    logic        classify_s, busy_s, done_s;
    logic [7:0]  win_idx_s;

    logic [7:0] pix_mem_s [16];
    logic [7:0] wt_mem_s  [4];

    always @(posedge clk) begin
        pix_data_s <= pix_mem_s[pix_addr_s];
        wt_data_s  <= wt_mem_s[wt_addr_s];
    end

    ann_window_sequencer #(
        .N_INPUTS  (4),
        .N_WINDOWS (1),
        .PIX_AW    (4),
        .WT_AW     (2)
    ) dut_s (
        .Clk      (clk),
        .RST      (rst),
        .start    (start_s),
        .pix_addr (pix_addr_s),
        .pix_data (pix_data_s),
        .wt_addr  (wt_addr_s),
        .wt_data  (wt_data_s),
        .bias     (bias_s),
        .Z        (Z_s),
        .classify (classify_s),
        .win_idx  (win_idx_s),
        .busy     (busy_s),
`ifdef ANN_SEQ_ABORT_EN
        .abort    (1'b0),
`endif
        .done     (done_s)
    );

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          frame_no = 0;
    logic [31:0] z_hold;
    int          exp_z [NW];

    typedef struct packed {
        logic [3:0][7:0] pix;
        logic [3:0][7:0] wt;
        logic [15:0]     bias;
        logic [31:0]     exp_z;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                                input int w0, input int w1, input int w2, input int w3,
                                input int b, input int z);
        vec_t v;
        v.pix[0] = 8'(p0); v.pix[1] = 8'(p1); v.pix[2] = 8'(p2); v.pix[3] = 8'(p3);
        v.wt[0]  = 8'(w0); v.wt[1]  = 8'(w1); v.wt[2]  = 8'(w2); v.wt[3]  = 8'(w3);
        v.bias   = 16'(b);
        v.exp_z  = 32'(z);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d (0x%h), expected %0d (0x%h)",
                     name, cyc, $signed(act), act, $signed(exp_v), exp_v);
        end
    endtask

    // Fill memories and compute each window's expected sum directly from the
    // definition: sum of pixel*weight over the window, plus bias.
    task automatic prep(input int data_mode);
        for (int i = 0; i < NW * NI; i++)
            pix_mem[i] = (data_mode == 1) ? 8'h80 : 8'($urandom);
        for (int i = 0; i < NI; i++)
            wt_mem[i] = (data_mode == 1) ? 8'h7f : 8'($urandom);
        bias = (data_mode == 1) ? 16'h0000 : 16'($urandom);
        for (int w = 0; w < NW; w++) begin
            int s;
            s = int'($signed(bias));
            for (int k = 0; k < NI; k++)
                s += int'($signed(pix_mem[w * NI + k])) * int'($signed(wt_mem[k]));
            exp_z[w] = s;
        end
    endtask

    // start_mode: 0 = single start pulse, 1 = extra start pulse in window 5,
    //             2 = leave start high at the end (next frame starts from it).
    // stop_c > 0: interrupt at that frame cycle (stop_kind 0 = RST, 1 = abort).
    task automatic run_frame(input int data_mode, input int start_mode,
                             input int stop_c, input int stop_kind);
        int n_strobe;
        n_strobe = 0;
        prep(data_mode);
        start = 1'b1;
        tick();
        if (start_mode != 2) start = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            int w, r;
            w = (c - 1) / WP;
            r = (c - 1) % WP;
            if (classify) n_strobe++;
            if (c < FRAME) begin
                if (r == WP - 1) z_hold = 32'(exp_z[w]);
                check("busy", 32'(busy), 32'd1);
                check("done", 32'(done), 32'd0);
                check("classify", 32'(classify), 32'(r == WP - 1));
                check("win_idx", 32'(win_idx), 32'(w));
                check("Z", Z, z_hold);
                if (r < NI) begin
                    check("pix_addr", 32'(pix_addr), 32'(w * NI + r));
                    check("wt_addr", 32'(wt_addr), 32'(r));
                end
                if (r == WP - 1) begin
                    if (data_mode == 1) check("Z_extreme", Z, 32'(-1040384));
                    $display("frame %0d window %0d Z=%0d", frame_no, win_idx, $signed(Z));
                end
            end else begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_in_done", 32'(busy), 32'd1);
                check("classify_in_done", 32'(classify), 32'd0);
                check("win_idx_in_done", 32'(win_idx), 32'(NW - 1));
                check("Z_in_done", Z, z_hold);
            end
            if (start_mode == 1) start = (c == 5 * WP + 10);
            if (c == stop_c) begin
                if (stop_kind == 0) rst = 1'b1;
`ifdef ANN_SEQ_ABORT_EN
                else abort = 1'b1;
`endif
                tick();
                rst = 1'b0;
`ifdef ANN_SEQ_ABORT_EN
                abort = 1'b0;
`endif
                frame_no++;
                return;
            end
            tick();
        end
        check("strobe_count", 32'(n_strobe), 32'(NW));
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_classify", 32'(classify), 32'd0);
        check("idle_Z", Z, z_hold);
        frame_no++;
    endtask

    task automatic quiet_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check("quiet_classify", 32'(classify), 32'd0);
            check("quiet_done", 32'(done), 32'd0);
            check("quiet_busy", 32'(busy), 32'd0);
            check("quiet_Z", Z, z_hold);
            tick();
        end
    endtask

    initial begin
        vecs[0] = mk(1, 2, 3, 4,            1, 1, 1, 1,               -5,     5);
        vecs[1] = mk(-128, -128, -128, -128, 127, 127, 127, 127,      0,      -65024);
        vecs[2] = mk(-128, -128, -128, -128, -128, -128, -128, -128,  32767,  98303);
        vecs[3] = mk(10, -20, 30, -40,      3, 5, -7, 2,              100,    -260);
        vecs[4] = mk(0, 0, 0, 0,            5, 6, 7, 8,               -32768, -32768);
        vecs[5] = mk(127, 127, 127, 127,    127, 127, 127, 127,       -1,     64515);
        vecs[6] = mk(-1, 2, -3, 4,          -128, 127, -128, 127,     7,      1281);

        rst = 1'b1; start = 1'b0; start_s = 1'b0; bias = '0; bias_s = '0;
`ifdef ANN_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 4096; i++) pix_mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) wt_mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) pix_mem_s[i] = 8'h00;
        for (int i = 0; i < 4; i++) wt_mem_s[i] = 8'h00;
        z_hold = '0;

        tick(); tick(); tick();
        check("rst_Z", Z, 32'd0);
        check("rst_classify", 32'(classify), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_win_idx", 32'(win_idx), 32'd0);
        check("rst_pix_addr", 32'(pix_addr), 32'd0);
        check("rst_wt_addr", 32'(wt_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Single-window vectors: classify 6 cycles after start, done one later.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) begin
                pix_mem_s[k] = vecs[i].pix[k];
                wt_mem_s[k]  = vecs[i].wt[k];
            end
            bias_s  = vecs[i].bias;
            start_s = 1'b1;
            tick();
            start_s = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                if (c <= 4) check("s_pix_addr", 32'(pix_addr_s), 32'(c - 1));
                if (c <= 6) check("s_classify", 32'(classify_s), 32'(c == 6));
                if (c == 6) begin
                    check("s_Z", Z_s, vecs[i].exp_z);
                    $display("single vector %0d Z=%0d", i, $signed(Z_s));
                end
                check("s_done", 32'(done_s), 32'(c == 7));
                check("s_busy", 32'(busy_s), 32'(c <= 7));
                tick();
            end
        end

        run_frame(0, 0, 0, 0);              // random data
        run_frame(1, 0, 0, 0);              // signed extremes
        run_frame(0, 1, 0, 0);              // start pulsed while busy
        run_frame(0, 2, 0, 0);              // start held high ...
        run_frame(0, 0, 0, 0);              // ... next frame follows DONE's IDLE

        // Reset during window 10's LOAD.
        run_frame(0, 0, 10 * WP + 20, 0);
        z_hold = '0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_Z", Z, 32'd0);
        check("midrst_win_idx", 32'(win_idx), 32'd0);
        check("midrst_classify", 32'(classify), 32'd0);
        check("midrst_pix_addr", 32'(pix_addr), 32'd0);
        check("midrst_wt_addr", 32'(wt_addr), 32'd0);
        quiet_cycles(200);
        run_frame(0, 0, 0, 0);

`ifdef ANN_SEQ_ABORT_EN
        // Abort during window 7's DRAIN.
        run_frame(0, 0, 7 * WP + 65, 1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_classify", 32'(classify), 32'd0);
        check("abort_Z", Z, z_hold);
        quiet_cycles(150);
        run_frame(0, 0, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
